// File: rtl/read_dat_extract_pkg.sv
// Shared types and helpers for the read-data extractor.
package read_dat_extract_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowestSetIdx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // log2(wideW / baseW) for power-of-two ratios.
  function automatic int unsigned slotRatioLog2(input int unsigned wideW, input int unsigned baseW);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((baseW << i) == wideW) n = i;
    end
    return n;
  endfunction

endpackage

// File: rtl/read_dat_slice.sv
// Selects one sub-word from the captured wide word and zero/sign-extends it.
module read_dat_slice
  import read_dat_extract_pkg::*;
#(
  parameter int unsigned WIDTH_TYPE_NUM = 3,
  parameter int unsigned WIDTH_DATA_IN  = 64,
  parameter int unsigned WIDTH_DATA_OUT = 32,
  parameter int unsigned MULTI_DATA_WIDTH [WIDTH_TYPE_NUM] = '{8, 16, 32},
  parameter int unsigned TYPE_W = 2,
  parameter int unsigned SLOT_W = 3
) (
  input  logic [WIDTH_DATA_IN-1:0]  dat,
  input  logic [TYPE_W-1:0]         typeIdx,
  input  logic                      typeZero,
  input  logic                      sign,
  input  logic [SLOT_W-1:0]         slot,
  output logic [WIDTH_DATA_OUT-1:0] ext
);

  logic [WIDTH_DATA_OUT-1:0] extByType [WIDTH_TYPE_NUM];

  // One extractor per width type; the mux below picks the active one.
  for (genvar g = 0; g < WIDTH_TYPE_NUM; g++) begin : gType
    localparam int unsigned W = MULTI_DATA_WIDTH[g];
    logic [W-1:0] part;
    assign part = W'(dat >> (32'(slot) * W));
    if (W < WIDTH_DATA_OUT) begin : gExt
      assign extByType[g] = {{(WIDTH_DATA_OUT - W){sign & part[W-1]}}, part};
    end else begin : gNoExt
      assign extByType[g] = part[WIDTH_DATA_OUT-1:0];
    end
  end

  // Pick the extended slice of the captured type; an empty type select yields zero.
  always_comb begin
    ext = '0;
    if (!typeZero) begin
      for (int unsigned i = 0; i < WIDTH_TYPE_NUM; i++) begin
        if (typeIdx == TYPE_W'(i)) ext = extByType[i];
      end
    end
  end

endmodule

// File: rtl/read_dat_extract.sv
// Captures a wide word and streams a burst of extended sub-words with valid/ready.
module read_dat_extract
  import read_dat_extract_pkg::*;
#(
  parameter int unsigned WIDTH_TYPE_NUM = 3,
  parameter int unsigned WIDTH_ADDR     = 4,
  parameter int unsigned WIDTH_DATA_IN  = 64,
  parameter int unsigned WIDTH_DATA_OUT = 32,
  parameter int unsigned MULTI_DATA_WIDTH [WIDTH_TYPE_NUM] = '{8, 16, 32},
  parameter int unsigned ADDR_TYPE      = 0,
  parameter int unsigned WIDTH_LEN      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iVld,
  output logic                      iRdy,
  input  logic [WIDTH_TYPE_NUM-1:0] iEn,
  input  logic                      iSign,
  input  logic [WIDTH_ADDR-1:0]     iAddr,
  input  logic [WIDTH_LEN-1:0]      iLen,
  input  logic [WIDTH_DATA_IN-1:0]  iDat,
  output logic                      oVld,
  input  logic                      oRdy,
  output logic [WIDTH_DATA_OUT-1:0] oDat,
  output logic                      oLast
);

  localparam int unsigned TYPE_W    = (WIDTH_TYPE_NUM > 1) ? $clog2(WIDTH_TYPE_NUM) : 1;
  localparam int unsigned MAX_SLOTS = WIDTH_DATA_IN / MULTI_DATA_WIDTH[0];
  localparam int unsigned SLOT_W    = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

  // Parameter sanity: each width fits the output, tiles the input, and gives 2^n slots.
  for (genvar g = 0; g < WIDTH_TYPE_NUM; g++) begin : gCheck
    localparam int unsigned W     = MULTI_DATA_WIDTH[g];
    localparam int unsigned SLOTS = WIDTH_DATA_IN / W;
    if (W > WIDTH_DATA_OUT) begin : gErrOut
      $error("MULTI_DATA_WIDTH[%0d]=%0d exceeds WIDTH_DATA_OUT", g, W);
    end
    if ((WIDTH_DATA_IN % W) != 0) begin : gErrDiv
      $error("MULTI_DATA_WIDTH[%0d]=%0d does not divide WIDTH_DATA_IN", g, W);
    end
    if ((SLOTS & (SLOTS - 1)) != 0) begin : gErrPow
      $error("slot count %0d for type %0d is not a power of two", SLOTS, g);
    end
  end

  state_t                     state, stateNxt;
  logic [WIDTH_DATA_IN-1:0]   datReg, datNxt;
  logic [TYPE_W-1:0]          typeReg, typeNxt;
  logic                       zeroReg, zeroNxt;
  logic                       signReg, signNxt;
  logic [SLOT_W-1:0]          slotReg, slotNxt;
  logic [WIDTH_LEN-1:0]       cntReg, cntNxt;

  logic [TYPE_W-1:0]          reqType;
  logic [SLOT_W-1:0]          startSlot;
  logic [SLOT_W-1:0]          curMask;
  logic                       beat;
  logic                       accept;

  assign oVld   = (state == BURST);
  assign oLast  = oVld & (cntReg == '0);
  assign beat   = oVld & oRdy;
  assign iRdy   = (state == IDLE) | (beat & oLast);
  assign accept = iVld & iRdy;
  assign reqType = TYPE_W'(lowestSetIdx(32'(iEn)));

  // Slot wrap mask for the captured type and start slot for the incoming request.
  always_comb begin
    curMask   = '0;
    startSlot = '0;
    for (int unsigned i = 0; i < WIDTH_TYPE_NUM; i++) begin
      if (typeReg == TYPE_W'(i)) begin
        curMask = SLOT_W'(WIDTH_DATA_IN / MULTI_DATA_WIDTH[i] - 1);
      end
      if (reqType == TYPE_W'(i)) begin
        if (ADDR_TYPE == 0) begin
          startSlot = SLOT_W'((32'(iAddr) >> slotRatioLog2(MULTI_DATA_WIDTH[i], MULTI_DATA_WIDTH[0]))
                              & (WIDTH_DATA_IN / MULTI_DATA_WIDTH[i] - 1));
        end else begin
          startSlot = SLOT_W'(32'(iAddr) & (WIDTH_DATA_IN / MULTI_DATA_WIDTH[i] - 1));
        end
      end
    end
  end

  // Next-state and burst context update; a new accept always reloads the context.
  always_comb begin
    stateNxt = state;
    datNxt   = datReg;
    typeNxt  = typeReg;
    zeroNxt  = zeroReg;
    signNxt  = signReg;
    slotNxt  = slotReg;
    cntNxt   = cntReg;
    case (state)
      IDLE: begin
        if (accept) stateNxt = BURST;
      end
      BURST: begin
        if (beat) begin
          if (oLast) begin
            stateNxt = accept ? BURST : IDLE;
          end else begin
            slotNxt = (slotReg + SLOT_W'(1)) & curMask;
            cntNxt  = cntReg - WIDTH_LEN'(1);
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (accept) begin
      datNxt  = iDat;
      typeNxt = reqType;
      zeroNxt = (iEn == '0);
      signNxt = iSign;
      slotNxt = startSlot;
      cntNxt  = iLen;
    end
  end

  // State and captured context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      datReg  <= '0;
      typeReg <= '0;
      zeroReg <= 1'b0;
      signReg <= 1'b0;
      slotReg <= '0;
      cntReg  <= '0;
    end else begin
      state   <= stateNxt;
      datReg  <= datNxt;
      typeReg <= typeNxt;
      zeroReg <= zeroNxt;
      signReg <= signNxt;
      slotReg <= slotNxt;
      cntReg  <= cntNxt;
    end
  end

  read_dat_slice #(
    .WIDTH_TYPE_NUM   (WIDTH_TYPE_NUM),
    .WIDTH_DATA_IN    (WIDTH_DATA_IN),
    .WIDTH_DATA_OUT   (WIDTH_DATA_OUT),
    .MULTI_DATA_WIDTH (MULTI_DATA_WIDTH),
    .TYPE_W           (TYPE_W),
    .SLOT_W           (SLOT_W)
  ) uSlice (
    .dat      (datReg),
    .typeIdx  (typeReg),
    .typeZero (zeroReg),
    .sign     (signReg),
    .slot     (slotReg),
    .ext      (oDat)
  );

endmodule

// File: tb/tb_read_dat_extract.sv
// Bench for read_dat_extract: directed plan scenarios plus randomized traffic vs a beat-queue model.
module tb_read_dat_extract;

  localparam logic [63:0] D = 64'h8877_6655_4433_2211;

  logic        clk;
  logic        rst;
  logic        iVld;
  logic        iRdy;
  logic [2:0]  iEn;
  logic        iSign;
  logic [3:0]  iAddr;
  logic [3:0]  iLen;
  logic [63:0] iDat;
  logic        oVld;
  logic        oRdy;
  logic [31:0] oDat;
  logic        oLast;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } beat_t;

  beat_t q[$];

  read_dat_extract dut (
    .clk   (clk),
    .rst   (rst),
    .iVld  (iVld),
    .iRdy  (iRdy),
    .iEn   (iEn),
    .iSign (iSign),
    .iAddr (iAddr),
    .iLen  (iLen),
    .iDat  (iDat),
    .oVld  (oVld),
    .oRdy  (oRdy),
    .oDat  (oDat),
    .oLast (oLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value of beat k of a burst, straight from the sub-word rules.
  function automatic logic [31:0] refBeat(input logic [63:0] d, input logic [2:0] en,
                                          input logic sg, input logic [3:0] addr, input int k);
    int idx;
    int w;
    int slots;
    int a;
    int slot;
    logic [63:0] v;
    logic [31:0] r;
    idx = -1;
    for (int i = 2; i >= 0; i--) if (en[i]) idx = i;
    if (idx < 0) return 32'd0;
    w     = 8 << idx;
    slots = 64 / w;
    a     = int'(addr);
    slot  = ((a / (w / 8)) % slots + k) % slots;
    v     = d >> (slot * w);
    v     = v & ((64'd1 << w) - 64'd1);
    r     = v[31:0];
    if (sg && w < 32 && r[w-1]) r = r | ~((32'd1 << w) - 32'd1);
    return r;
  endfunction

  // Model: queue of pending beats; accept allowed when empty or on the final beat.
  always @(posedge clk or posedge rst) begin
    logic rdy;
    beat_t b;
    if (rst) begin
      q.delete();
    end else begin
      rdy = (q.size() == 0) || (oRdy && q[0].last);
      if (q.size() != 0 && oRdy) void'(q.pop_front());
      if (iVld && rdy) begin
        for (int k = 0; k <= int'(iLen); k++) begin
          b.dat  = refBeat(iDat, iEn, iSign, iAddr, k);
          b.last = (k == int'(iLen));
          q.push_back(b);
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      chk("cmp_oVld", 32'(oVld), 32'd1);
      chk("cmp_oDat", oDat, q[0].dat);
      chk("cmp_oLast", 32'(oLast), 32'(q[0].last));
      chk("cmp_iRdy", 32'(iRdy), 32'(oRdy & q[0].last));
    end else begin
      chk("cmp_oVld_idle", 32'(oVld), 32'd0);
      chk("cmp_oLast_idle", 32'(oLast), 32'd0);
      chk("cmp_iRdy_idle", 32'(iRdy), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic [2:0] en, input logic sg, input logic [3:0] addr,
                        input logic [3:0] len, input logic [63:0] d);
    iVld  = 1'b1;
    iEn   = en;
    iSign = sg;
    iAddr = addr;
    iLen  = len;
    iDat  = d;
  endtask

  task automatic expBeat(input string nm, input logic [31:0] d, input logic l);
    @(negedge clk);
    chk(nm, 32'(oVld), 32'd1);
    chk(nm, oDat, d);
    chk(nm, 32'(oLast), 32'(l));
  endtask

  initial begin
    rst = 1'b1; iVld = 1'b0; iEn = '0; iSign = 1'b0; iAddr = '0; iLen = '0; iDat = '0; oRdy = 1'b1;

    // Pin the model with hand-derived values.
    chk("model_byte_b1", refBeat(D, 3'b001, 1'b0, 4'd6, 1), 32'h0000_0088);
    chk("model_byte_wrap", refBeat(D, 3'b001, 1'b0, 4'd6, 2), 32'h0000_0011);
    chk("model_half_sx", refBeat(D, 3'b010, 1'b1, 4'd6, 0), 32'hFFFF_8877);
    chk("model_word", refBeat(D, 3'b100, 1'b0, 4'd4, 0), 32'h8877_6655);
    chk("model_en0", refBeat(D, 3'b000, 1'b1, 4'd3, 0), 32'h0000_0000);

    @(negedge clk);
    chk("reset_oVld", 32'(oVld), 32'd0);
    chk("reset_oLast", 32'(oLast), 32'd0);
    chk("reset_oDat", oDat, 32'd0);
    chk("reset_iRdy", 32'(iRdy), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();

    // Byte burst with wrap.
    setReq(3'b001, 1'b0, 4'd6, 4'd3, D);
    tick(); iVld = 1'b0;
    expBeat("byte_b0", 32'h77, 1'b0); tick();
    expBeat("byte_b1", 32'h88, 1'b0); tick();
    expBeat("byte_b2", 32'h11, 1'b0); tick();
    expBeat("byte_b3", 32'h22, 1'b1); tick();

    // Sign-extended half-word.
    setReq(3'b010, 1'b1, 4'd6, 4'd0, D);
    tick(); iVld = 1'b0;
    expBeat("half_sx", 32'hFFFF_8877, 1'b1); tick();
    @(negedge clk);
    chk("half_then_idle_vld", 32'(oVld), 32'd0);
    chk("half_then_idle_rdy", 32'(iRdy), 32'd1);
    tick();

    // Full-width word.
    setReq(3'b100, 1'b0, 4'd4, 4'd0, D);
    tick(); iVld = 1'b0; iDat = '1;
    expBeat("word", 32'h8877_6655, 1'b1); tick();

    // Backpressure on beat 2.
    setReq(3'b001, 1'b0, 4'd6, 4'd3, D);
    tick(); iVld = 1'b0; iDat = '0;
    expBeat("bp_b0", 32'h77, 1'b0); tick();
    expBeat("bp_b1", 32'h88, 1'b0);
    #1 oRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expBeat("bp_hold", 32'h88, 1'b0);
      chk("bp_iRdy", 32'(iRdy), 32'd0);
    end
    #1 oRdy = 1'b1;
    tick();
    expBeat("bp_b2", 32'h11, 1'b0); tick();
    expBeat("bp_b3", 32'h22, 1'b1); tick();

    // Back-to-back request on the final beat.
    setReq(3'b001, 1'b0, 4'd6, 4'd3, D);
    tick(); iVld = 1'b0;
    expBeat("b2b_b0", 32'h77, 1'b0); tick();
    expBeat("b2b_b1", 32'h88, 1'b0); tick();
    expBeat("b2b_b2", 32'h11, 1'b0); tick();
    expBeat("b2b_b3", 32'h22, 1'b1);
    #1 setReq(3'b001, 1'b0, 4'd0, 4'd0, D);
    #1 chk("b2b_iRdy", 32'(iRdy), 32'd1);
    tick(); iVld = 1'b0;
    expBeat("b2b_next", 32'h11, 1'b1); tick();
    @(negedge clk);
    chk("b2b_idle", 32'(oVld), 32'd0);
    tick();

    // Reset mid-burst.
    setReq(3'b001, 1'b0, 4'd6, 4'd3, D);
    tick(); iVld = 1'b0;
    expBeat("rst_b0", 32'h77, 1'b0); tick();
    expBeat("rst_b1", 32'h88, 1'b0);
    #1 rst = 1'b1;
    #1 chk("rst_async_oVld", 32'(oVld), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_after_iRdy", 32'(iRdy), 32'd1);
    chk("rst_after_oDat", oDat, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_residual", 32'(oVld), 32'd0);
    end
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      iVld  = ($urandom_range(0, 2) != 0);
      iEn   = 3'($urandom_range(0, 7));
      iSign = 1'($urandom_range(0, 1));
      iAddr = 4'($urandom_range(0, 15));
      iLen  = 4'($urandom_range(0, 9));
      iDat  = {$urandom, $urandom};
      oRdy  = ($urandom_range(0, 3) != 0);
      tick();
    end
    iVld = 1'b0;
    oRdy = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("drain_empty", 32'(oVld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_dat_extract.md
# read_dat_extract

Sequential read-side counterpart of the write-data extender. It captures one wide data word together with a width type and a start address. It then streams a burst of narrow sub-words out of that word, one per accepted beat, each zero- or sign-extended to the output width. It sits between a wide memory or register read port and a narrow consumer, using valid/ready on both sides.

## Interface
- WIDTH_TYPE_NUM, 3, number of sub-word width types
- WIDTH_ADDR, 4, width of iAddr
- WIDTH_DATA_IN, 64, width of captured wide word
- WIDTH_DATA_OUT, 32, width of extended output
- MULTI_DATA_WIDTH[WIDTH_TYPE_NUM], {8,16,32}, sub-word width per type, ascending
- ADDR_TYPE, 0, 0: iAddr in units of MULTI_DATA_WIDTH[0]; 1: iAddr is slot index directly
- WIDTH_LEN, 4, width of iLen

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iVld  in  1  request valid
- iRdy  out  1  request ready
- iEn  in  WIDTH_TYPE_NUM  width-type select, one-hot
- iSign  in  1  1 = sign-extend, 0 = zero-extend
- iAddr  in  WIDTH_ADDR  start address
- iLen  in  WIDTH_LEN  burst length minus one
- iDat  in  WIDTH_DATA_IN  wide word, sampled at accept
- oVld  out  1  beat valid
- oRdy  in  1  beat ready
- oDat  out  WIDTH_DATA_OUT  extended sub-word
- oLast  out  1  final beat of burst

## Operation
- States: IDLE, BURST.
- **IDLE**
  - iRdy=1.
  - On iVld&iRdy, register iDat, the selected type, iSign, the start slot and iLen as the remaining count; go to BURST.
- **Type select**
  - Lowest set bit of iEn wins.
  - iEn=0 is accepted; every beat of that burst outputs all zeros.
- **Slot count**
  - For type i, SLOTS_i = WIDTH_DATA_IN/MULTI_DATA_WIDTH[i].
- **Start slot**
  - ADDR_TYPE=0: iAddr >> log2(MULTI_DATA_WIDTH[i]/MULTI_DATA_WIDTH[0]), modulo SLOTS_i.
  - ADDR_TYPE=1: iAddr modulo SLOTS_i.
- **BURST**
  - oVld=1.
  - oDat = bits [slot*W+:W] of the captured word, extended to WIDTH_DATA_OUT.
  - Sign extension uses bit W-1 of the slice.
  - If W==WIDTH_DATA_OUT, no extension is applied.
  - oLast=1 when the remaining count is 0.
  - On oVld&oRdy with oLast=0: slot increments, wrapping SLOTS_i-1 to 0; count decrements.
  - On oVld&oRdy with oLast=1: return to IDLE, unless a new request is accepted in the same cycle.
- **Back-to-back**
  - iRdy = (state==IDLE) | (oVld&oRdy&oLast).
  - This is a combinational path from oRdy to iRdy.
  - A request accepted on the last beat loads the new context and stays in BURST.
- **Elaboration checks** ($error): each MULTI_DATA_WIDTH[i] ≤ WIDTH_DATA_OUT, divides WIDTH_DATA_IN, and gives a power-of-two SLOTS_i.

## Timing
- **Reset values:** state IDLE; oVld=0, oLast=0, oDat=0 (captured registers cleared); iRdy=1.
- **Latency:** request accepted at edge N → first beat valid from cycle N+1.
- **Throughput:** one beat per cycle while oRdy=1. A burst of L+1 beats takes L+1 cycles; consecutive bursts have no gap.
- **Backpressure:** while oVld=1 and oRdy=0, oDat, oLast and the slot are held; no beat is dropped or repeated; iRdy=0.
- **iDat** is sampled only at accept; later changes do not affect the burst.
- **Wrap:** a burst longer than SLOTS_i wraps and repeats slots.
- **Reset mid-burst:** the burst is abandoned and oVld falls asynchronously. After release: IDLE, iRdy=1, no residual beats.

## Structure
- Shared package holds:
  - the state enum typedef (IDLE, BURST);
  - a function returning the index of the lowest set bit of a vector;
  - a function computing log2 of the slot ratio.
- One sub-module, read_dat_slice: combinational slice select plus zero/sign extension for a given type, slot and sign. The FSM, counters and handshake stay in the top module.

## Test plan
Configuration for all scenarios: defaults; D = 64'h8877_6655_4433_2211.
- **Byte burst with wrap:** iDat=D, iEn=001, iAddr=6, iLen=3, iSign=0, oRdy=1 → oDat 0x77, 0x88, 0x11, 0x22 on consecutive cycles; oLast only on the 4th.
- **Sign-extended half-word:** iEn=010, iAddr=6 (slot 3), iLen=0, iSign=1 → single beat oDat=0xFFFF8877, oLast=1; then IDLE, iRdy=1.
- **Full-width word:** iEn=100, iAddr=4 (slot 1), iLen=0 → oDat=0x88776655.
- **Backpressure:** byte burst as above with oRdy=0 for 3 cycles after beat 2 → oDat held at 0x88, iRdy=0; remaining beats 0x11, 0x22 follow with none lost.
- **Back-to-back:** a second request (iEn=001, iAddr=0, iLen=0) presented with iVld=1 during the last beat → accepted that cycle; next cycle oVld=1 with oDat=0x11, no idle gap.
- **Reset mid-burst:** assert rst during beat 2 of 4 → oVld=0 immediately; after release iRdy=1, oDat=0, and no further beats.
